// File: rtl/adc2_cfg_sequencer.sv
// adc2_cfg_sequencer: streams the fixed ADC2 configuration table into the
// spi_adc2 engine, one word per send/busy handshake, with an inter-word gap
// and a longer settle wait after the soft-reset word.
module adc2_cfg_sequencer #(
    parameter int unsigned WORD_W      = 24,
    parameter int unsigned RESET_WAIT  = 100,
    parameter int unsigned GAP         = 24,
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned AUTO_START  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              spi_busy,
    output logic              send,
    output logic [WORD_W-1:0] pattern,
    output logic [3:0]        word_idx,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int unsigned MAX_AB  = (RESET_WAIT > GAP) ? RESET_WAIT : GAP;
    localparam int unsigned MAX_CNT = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [3:0] LAST_IDX = 4'd10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_ACK  = 3'd3;
    localparam logic [2:0] S_XFER = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              auto_pend, auto_pend_d;
    logic              send_d;
    logic [WORD_W-1:0] pattern_d;
    logic [3:0]        word_idx_d;
    logic              cfg_busy_d, cfg_done_d, cfg_err_d;

    // Constant configuration ROM; index 10 is the commit word and always last.
    function automatic logic [23:0] cfg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_word = 24'h00003C;
            4'd1:    cfg_word = 24'h000503;
            4'd2:    cfg_word = 24'h000B00;
            4'd3:    cfg_word = 24'h000F01;
            4'd4:    cfg_word = 24'h001440;
            4'd5:    cfg_word = 24'h001719;
            4'd6:    cfg_word = 24'h0018C0;
            4'd7:    cfg_word = 24'h000D00;
            4'd8:    cfg_word = 24'h001000;
            4'd9:    cfg_word = 24'h003000;
            4'd10:   cfg_word = 24'h00FF01;
            default: cfg_word = 24'h000000;
        endcase
    endfunction

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            auto_pend <= (AUTO_START != 0);
            send      <= 1'b0;
            pattern   <= '0;
            word_idx  <= 4'd0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            auto_pend <= auto_pend_d;
            send      <= send_d;
            pattern   <= pattern_d;
            word_idx  <= word_idx_d;
            cfg_busy  <= cfg_busy_d;
            cfg_done  <= cfg_done_d;
            cfg_err   <= cfg_err_d;
        end
    end

    // Next-state and next-output logic; outputs lag the state by one register.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        auto_pend_d = auto_pend;
        send_d      = 1'b0;
        pattern_d   = pattern;
        word_idx_d  = word_idx;
        cfg_busy_d  = cfg_busy;
        cfg_done_d  = cfg_done;
        cfg_err_d   = cfg_err;

        case (state)
            S_IDLE: begin
                if (start || auto_pend) begin
                    state_d     = S_LOAD;
                    auto_pend_d = 1'b0;
                    word_idx_d  = 4'd0;
                    cfg_done_d  = 1'b0;
                    cfg_err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                pattern_d  = WORD_W'(cfg_word(word_idx));
                cfg_busy_d = 1'b1;
                state_d    = S_SEND;
            end
            S_SEND: begin
                send_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_ACK;
            end
            S_ACK: begin
                if (spi_busy) begin
                    state_d = S_XFER;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // Engine never acknowledged: abandon the rest of the table.
                    cfg_err_d  = 1'b1;
                    cfg_busy_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_XFER: begin
                if (!spi_busy) begin
                    cnt_d   = (word_idx == 4'd0) ? CNT_W'(RESET_WAIT) : CNT_W'(GAP);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt <= CNT_W'(1)) begin
                    cnt_d = '0;
                    if (word_idx == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        word_idx_d = word_idx + 4'd1;
                        state_d    = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                cfg_done_d = 1'b1;
                cfg_busy_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc2_cfg_sequencer.sv
// Directed bench for adc2_cfg_sequencer with a behavioural spi_adc2 model.
module tb_adc2_cfg_sequencer;

    localparam int unsigned WORD_W = 24;
    localparam int EXP_RST_GAP = 103;   // XFER exit + 100 GAP + LOAD + SEND
    localparam int EXP_GAP     = 27;    // XFER exit + 24 GAP + LOAD + SEND

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              spi_busy;
    logic              send;
    logic [WORD_W-1:0] pattern;
    logic [3:0]        word_idx;
    logic              cfg_busy;
    logic              cfg_done;
    logic              cfg_err;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_tbl [0:10] = '{24'h00003C, 24'h000503, 24'h000B00, 24'h000F01,
                                    24'h001440, 24'h001719, 24'h0018C0, 24'h000D00,
                                    24'h001000, 24'h003000, 24'h00FF01};

    adc2_cfg_sequencer #(
        .WORD_W(24), .RESET_WAIT(100), .GAP(24), .ACK_TIMEOUT(15), .AUTO_START(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .spi_busy(spi_busy),
        .send(send), .pattern(pattern), .word_idx(word_idx),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used for gap timestamps.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy rises 2 cycles after send, stays high 24 cycles.
    logic drop_en = 1'b0;
    logic [3:0] drop_idx = 4'd0;
    logic eng_arm;
    int   eng_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_arm  <= 1'b0;
            eng_cnt  <= 0;
            spi_busy <= 1'b0;
        end else begin
            eng_arm <= send && !(drop_en && word_idx == drop_idx);
            if (eng_arm) begin
                spi_busy <= 1'b1;
                eng_cnt  <= 24;
            end else if (eng_cnt > 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) spi_busy <= 1'b0;
            end
        end
    end

    // Monitor: logs sends, fall-to-send gaps and pattern changes during a word.
    logic [23:0] sent_pat [$];
    int          sent_idx [$];
    int          gaps     [$];
    int          sends    = 0;
    int          stab_err = 0;
    logic        track = 1'b0, fall_seen = 1'b0, prev_busy = 1'b0;
    logic [23:0] held = '0;
    int          fall_cyc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            track = 1'b0; fall_seen = 1'b0; prev_busy = 1'b0;
        end else begin
            if (send) begin
                sent_pat.push_back(pattern);
                sent_idx.push_back(int'(word_idx));
                sends = sends + 1;
                if (fall_seen) gaps.push_back(cyc - fall_cyc);
                fall_seen = 1'b0;
                track = 1'b1;
                held = pattern;
            end else if (track && pattern !== held) begin
                stab_err = stab_err + 1;
            end
            if (prev_busy && !spi_busy) begin
                track = 1'b0; fall_seen = 1'b1; fall_cyc = cyc;
            end
            if (!cfg_busy) fall_seen = 1'b0;
            prev_busy = spi_busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_sends(input int n, input int budget, input string tag);
        int i = 0;
        while (sends < n && i < budget) begin tick(); i++; end
        chk(tag, 32'(sends >= n), 32'd1);
    endtask

    task automatic wait_end(input int budget, input string tag);
        int i = 0;
        while (!(cfg_done || cfg_err) && i < budget) begin tick(); i++; end
        chk(tag, 32'(cfg_done || cfg_err), 32'd1);
    endtask

    task automatic wait_idx(input logic [3:0] v, input int budget, input string tag);
        int i = 0;
        while (word_idx !== v && i < budget) begin tick(); i++; end
        chk(tag, 32'(word_idx), 32'(v));
    endtask

    task automatic wait_busy(input logic v, input int budget, input string tag);
        int i = 0;
        while (spi_busy !== v && i < budget) begin tick(); i++; end
        chk(tag, 32'(spi_busy), 32'(v));
    endtask

    // Verify one complete 11-word run logged from the given monitor offsets.
    task automatic check_run(input int bs, input int bg, input int bst, input string tag);
        chk({tag, "_sends"}, 32'(sends - bs), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (bs + i < sent_pat.size()) begin
                chk($sformatf("%s_pat%0d", tag, i), 32'(sent_pat[bs + i]), 32'(exp_tbl[i]));
                chk($sformatf("%s_idx%0d", tag, i), 32'(sent_idx[bs + i]), 32'(i));
            end
        end
        chk({tag, "_ngaps"}, 32'(gaps.size() - bg), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (bg + i < gaps.size())
                chk($sformatf("%s_gap%0d", tag, i), 32'(gaps[bg + i]),
                    32'((i == 0) ? EXP_RST_GAP : EXP_GAP));
        end
        chk({tag, "_stable"}, 32'(stab_err - bst), 32'd0);
        chk({tag, "_done"}, 32'(cfg_done), 32'd1);
        chk({tag, "_busy"}, 32'(cfg_busy), 32'd0);
        chk({tag, "_err"},  32'(cfg_err),  32'd0);
    endtask

    initial begin
        int bs, bg, bst;
        rst_n = 1'b0;
        start = 1'b0;
        tick(); tick();
        // Reset values.
        chk("rst_send",  32'(send),     32'd0);
        chk("rst_pat",   32'(pattern),  32'd0);
        chk("rst_idx",   32'(word_idx), 32'd0);
        chk("rst_busy",  32'(cfg_busy), 32'd0);
        chk("rst_done",  32'(cfg_done), 32'd0);
        chk("rst_err",   32'(cfg_err),  32'd0);

        // Automatic run after reset release.
        bs = sends; bg = gaps.size(); bst = stab_err;
        rst_n = 1'b1;
        wait_end(3000, "auto_end_timeout");
        tick();
        check_run(bs, bg, bst, "auto");

        // Restart via start, with exact start latency.
        tick(); tick();
        bs = sends; bg = gaps.size(); bst = stab_err;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_done_clr", 32'(cfg_done), 32'd0);
        chk("rs_busy_n0",  32'(cfg_busy), 32'd0);
        chk("rs_send_n0",  32'(send),     32'd0);
        tick();
        chk("rs_busy_n1",  32'(cfg_busy), 32'd1);
        chk("rs_send_n1",  32'(send),     32'd0);
        tick();
        chk("rs_send_n2",  32'(send),     32'd1);
        chk("rs_pat_n2",   32'(pattern),  32'h00003C);
        // Mid-sequence start must be ignored.
        wait_idx(4'd4, 1000, "rs_reach_idx4");
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rs_idx_hold", 32'(word_idx), 32'd4);
        wait_end(3000, "rs_end_timeout");
        tick();
        check_run(bs, bg, bst, "restart");

        // Ack timeout on word 3.
        drop_en = 1'b1; drop_idx = 4'd3;
        bs = sends;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_sends(bs + 4, 2000, "to_reach_send4");
        repeat (14) tick();
        chk("to_err_early", 32'(cfg_err),  32'd0);
        chk("to_busy_early", 32'(cfg_busy), 32'd1);
        tick();
        chk("to_err",       32'(cfg_err),  32'd1);
        chk("to_busy",      32'(cfg_busy), 32'd0);
        repeat (200) tick();
        chk("to_no_sends",  32'(sends - bs), 32'd4);
        chk("to_no_done",   32'(cfg_done), 32'd0);
        chk("to_idx",       32'(word_idx), 32'd3);
        drop_en = 1'b0;

        // Asynchronous reset during the gap after word 5.
        bs = sends;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ro_err_clr", 32'(cfg_err), 32'd0);
        wait_sends(bs + 6, 2000, "ro_reach_send6");
        wait_busy(1'b1, 20, "ro_busy_rise");
        wait_busy(1'b0, 40, "ro_busy_fall");
        repeat (5) tick();
        chk("ro_idx_pre", 32'(word_idx), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ro_send",  32'(send),     32'd0);
        chk("ro_pat",   32'(pattern),  32'd0);
        chk("ro_idx",   32'(word_idx), 32'd0);
        chk("ro_busy",  32'(cfg_busy), 32'd0);
        chk("ro_done",  32'(cfg_done), 32'd0);
        chk("ro_err",   32'(cfg_err),  32'd0);
        tick();
        bs = sends;
        rst_n = 1'b1;
        wait_sends(bs + 1, 50, "ro_first_send");
        if (bs < sent_pat.size())
            chk("ro_first_pat", 32'(sent_pat[bs]), 32'h00003C);
        wait_end(3000, "ro_end_timeout");
        tick();
        chk("ro_final_done", 32'(cfg_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
